key_event_encoder: RTL and testbench
====================================

// Module: key_event_encoder
// PURPOSE
//  Upstream input stage for the calculator datapath and LCD formatter.
//  - Synchronises and debounces the 12 key switches (sw) and 8 operator DIP switches (dipsw).
//  - Turns each clean single-key press into one event carrying kind, code and LCD ASCII byte.
//  - Buffers events in a small FIFO behind a valid/ready handshake, so the consumer sees exactly
//    one event per physical press, independent of hold time or contact bounce.
// PARAMETERS
//  TICK_DIV        5   clk cycles per debounce sample tick (>=1)
//  DEBOUNCE_TICKS  20  consecutive identical samples required to accept a new input vector (>=1)
//  FIFO_DEPTH      4   event FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  sw         in   12  key switches, asynchronous; sw[11..2] = digits 0..9, sw[1], sw[0] = clear
//  dipsw      in   8   operator switches, asynchronous; dipsw[7..0] = + - * / % ^ ! =
//  evt_valid  out  1   FIFO head holds an event
//  evt_ready  in   1   consumer accepts head this cycle
//  evt_kind   out  2   head kind: 00 digit, 01 operator, 10 clear, 11 unused
//  evt_code   out  4   digit value 0..9 / operator index 0..7 (dipsw[7]=0) / 0 for clear
//  evt_ascii  out  8   LCD char: 0x30+digit; clear 0x20; ops 2B,2D,D7,2F,F7,5E,21,3D
//  key_held   out  1   debounced vector nonzero
//  overflow   out  1   sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs and state are reset synchronously and take effect on the first posedge
//   with rst=1; rst mid-operation discards FIFO contents and any in-progress debounce.
//   - evt_valid=0, evt_kind=0, evt_code=0, evt_ascii=0x20, key_held=0, overflow=0
//   - FIFO empty; FSM=IDLE; debounced vector=0; tick counter=0; debounce counter=0
//  Input path: {sw,dipsw} (20 bits) pass through a 2-flop synchroniser.
//   - A tick pulses every TICK_DIV clk; the synchronised vector is sampled only on ticks.
//  Debounce:
//   - On a tick, sample == candidate -> cnt++ (saturating); sample != candidate -> candidate=sample, cnt=1.
//   - When cnt reaches DEBOUNCE_TICKS and candidate != stable, stable<=candidate on that same clk.
//   - key_held = |stable, registered.
//  FSM (evaluated every clk on stable):
//   - IDLE:    stable==0 -> stay; exactly one bit set -> EMIT; >1 bit set -> INVALID.
//   - EMIT:    push the decoded event for one clk -> HELD.
//   - HELD:    stay until stable==0 -> IDLE; bit changes while nonzero emit nothing.
//   - INVALID: no event; stay until stable==0 -> IDLE.
//   - A press therefore emits exactly once; a release emits nothing.
//   - sw and dipsw bits are treated alike: one sw plus one dipsw set together is INVALID.
//  Latency: stable update at edge N -> EMIT at N+1 -> FIFO write at N+2 -> evt_valid=1 after
//   edge N+2 when the FIFO was empty.
//  FIFO: show-ahead, so evt_* always reflects the head.
//   - Pop on evt_valid & evt_ready; evt_ready with evt_valid=0 is ignored.
//   - Push and pop in the same cycle are both performed, including when full, so no drop occurs.
//   - Push when full without pop: event discarded, overflow<=1 and held until rst.
//   - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
//   - When empty, evt_kind/code/ascii keep the last popped values; only evt_valid is meaningful.
// TESTING (bench params TICK_DIV=2, DEBOUNCE_TICKS=3, FIFO_DEPTH=4)
//  1. sw=12'h004 held 40 clk, evt_ready=1 -> exactly one event: kind=00, code=9, ascii=0x39.
//     Release -> no further events.
//  2. sw[10] toggles every 3 clk for 30 clk, then steady high 20 clk -> one event
//     (kind=00, code=1, ascii=0x31), none during bounce.
//  3. dipsw=8'h80 with sw=12'h800 pressed together -> no event; both released, then dipsw=8'h01
//     -> one event, kind=01, code=7, ascii=0x3D.
//  4. evt_ready=0, press/release digits 0,1,2,3,4 in turn -> head 0x30, FIFO holds 4, overflow=1.
//     Then ready=1 -> 0x30,0x31,0x32,0x33 in order and evt_valid=0.
//  5. FIFO full and ready=1 in the same cycle as a new push -> no drop; overflow stays 0.
//     sw=12'h001 pressed -> kind=10, code=0, ascii=0x20.
//  6. rst=1 for 1 clk while 2 events queued and a key mid-debounce -> next edge: evt_valid=0,
//     overflow=0, key_held=0; key still held after rst -> one event once re-debounced.

Source files
------------

// File: rtl/key_event_encoder.sv
// Key/DIP switch front end: synchronise, debounce, encode single presses
// into kind/code/ASCII events and queue them behind a valid/ready FIFO.
module key_event_encoder #(
    parameter int TICK_DIV       = 5,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    input  logic [7:0]  dipsw,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_kind,
    output logic [3:0]  evt_code,
    output logic [7:0]  evt_ascii,
    output logic        key_held,
    output logic        overflow
);

    localparam int NB   = 20;
    localparam int TW   = $clog2(TICK_DIV + 1);
    localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int EW   = 14;
    localparam logic [EW-1:0] EVT_RST = {2'b00, 4'h0, 8'h20};

    typedef enum logic [1:0] {IDLE, EMIT, HELD, INVALID} state_t;

    function automatic logic [7:0] op_ascii(input int idx);
        logic [7:0] a;
        case (idx)
            0:       a = 8'h2B;
            1:       a = 8'h2D;
            2:       a = 8'hD7;
            3:       a = 8'h2F;
            4:       a = 8'hF7;
            5:       a = 8'h5E;
            6:       a = 8'h21;
            default: a = 8'h3D;
        endcase
        return a;
    endfunction

    // Vector layout is {sw[11:0], dipsw[7:0]}; caller guarantees one-hot.
    function automatic logic [EW-1:0] decode(input logic [NB-1:0] v);
        logic [EW-1:0] r;
        r = EVT_RST;
        for (int i = 0; i < 12; i++) begin
            if (v[8+i]) begin
                if (i >= 2) r = {2'b00, 4'(11 - i), 8'(48 + 11 - i)};
                else        r = {2'b10, 4'h0, 8'h20};
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (v[j]) r = {2'b01, 4'(7 - j), op_ascii(7 - j)};
        end
        return r;
    endfunction

    logic [NB-1:0] sync1_q, sync2_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [NB-1:0] cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] stable_q, stable_d;
    logic          key_held_q, key_held_d;
    state_t        state_q, state_d;
    logic [NB-1:0] pend_q, pend_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [EW-1:0] head_q, head_d;
    logic          overflow_q, overflow_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic          tick, one_hot, push, pop, full, wr_en;
    logic [EW-1:0] push_data;

    always_comb begin
        tick       = tick_cnt_q == TW'(TICK_DIV - 1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        if (tick) begin
            if (sync2_q == cand_q) begin
                if (cnt_q < CW'(DEBOUNCE_TICKS)) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_d = sync2_q;
                cnt_d  = CW'(1);
            end
            if (cnt_d >= CW'(DEBOUNCE_TICKS) && cand_d != stable_q)
                stable_d = cand_d;
        end
        key_held_d = |stable_d;
    end

    assign one_hot = (stable_q != '0) && ((stable_q & (stable_q - 1'b1)) == '0);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (one_hot) begin
                    state_d = EMIT;
                    pend_d  = stable_q;
                end else if (stable_q != '0) begin
                    state_d = INVALID;
                end
            end
            EMIT:          state_d = HELD;
            HELD, INVALID: if (stable_q == '0) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_comb begin
        push      = state_q == EMIT;
        push_data = decode(pend_q);
    end

    // Head register tracks the next FIFO head so outputs stay show-ahead
    // and hold the last popped entry once the FIFO drains.
    always_comb begin
        pop        = (count_q != '0) && evt_ready;
        full       = count_q == NW'(FIFO_DEPTH);
        wr_en      = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
        head_d = head_q;
        if (pop) begin
            if (count_q > NW'(1)) head_d = mem_q[rd_ptr_q + AW'(1)];
            else if (wr_en)      head_d = push_data;
        end else if (count_q == '0 && wr_en) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            key_held_q <= 1'b0;
            state_q    <= IDLE;
            pend_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= EVT_RST;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= {sw, dipsw};
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            key_held_q <= key_held_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign evt_valid = count_q != '0;
    assign evt_kind  = head_q[13:12];
    assign evt_code  = head_q[11:8];
    assign evt_ascii = head_q[7:0];
    assign key_held  = key_held_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: one task per scenario, events
// captured at each accepted handshake and compared against fixed values.
module tb_key_event_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sw = '0;
    logic [7:0]  dipsw = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_kind;
    logic [3:0]  evt_code;
    logic [7:0]  evt_ascii;
    logic        key_held;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic [13:0] evq [$];

    key_event_encoder #(
        .TICK_DIV      (2),
        .DEBOUNCE_TICKS(3),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .dipsw    (dipsw),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_kind (evt_kind),
        .evt_code (evt_code),
        .evt_ascii(evt_ascii),
        .key_held (key_held),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && evt_valid && evt_ready)
            evq.push_back({evt_kind, evt_code, evt_ascii});
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [11:0] s, input logic [7:0] d);
        sw = s;
        dipsw = d;
        wait_clk(20);
        sw = '0;
        dipsw = '0;
        wait_clk(20);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b want=0", evt_valid);
        end
        checks++;
        if ({evt_kind, evt_code, evt_ascii} !== 14'h0020) begin
            errors++;
            $display("FAIL reset_head got=%h want=0020",
                     {evt_kind, evt_code, evt_ascii});
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL reset_key_held got=%b want=0", key_held);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got=%b want=0", overflow);
        end
    endtask

    task automatic test_single_digit;
        evq.delete();
        evt_ready = 1'b1;
        sw = 12'h004;
        wait_clk(40);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL t1_key_held got=%b want=1", key_held);
        end
        sw = '0;
        wait_clk(30);
        checks++;
        if (evq.size() != 1) begin
            errors++; $display("FAIL t1_count got=%0d want=1", evq.size());
        end else begin
            checks++;
            if (evq[0] !== {2'b00, 4'd9, 8'h39}) begin
                errors++; $display("FAIL t1_event got=%h want=0939", evq[0]);
            end
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL t1_release got=%b want=0", key_held);
        end
    endtask

    task automatic test_bounce;
        evq.delete();
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 12'h400 : 12'h000;
            wait_clk(3);
        end
        checks++;
        if (evq.size() != 0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL t2_bounce got=%0d/%b want=0/0", evq.size(), key_held);
        end
        sw = 12'h400;
        wait_clk(20);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL t2_key_held got=%b want=1", key_held);
        end
        sw = '0;
        wait_clk(30);
        checks++;
        if (evq.size() != 1) begin
            errors++; $display("FAIL t2_count got=%0d want=1", evq.size());
        end else begin
            checks++;
            if (evq[0] !== {2'b00, 4'd1, 8'h31}) begin
                errors++; $display("FAIL t2_event got=%h want=0131", evq[0]);
            end
        end
    endtask

    task automatic test_invalid_and_op;
        evq.delete();
        sw = 12'h800;
        dipsw = 8'h80;
        wait_clk(30);
        checks++;
        if (evq.size() != 0 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL t3_invalid got=%0d/%b want=0/1", evq.size(), key_held);
        end
        sw = '0;
        dipsw = '0;
        wait_clk(30);
        dipsw = 8'h01;
        wait_clk(30);
        dipsw = '0;
        wait_clk(30);
        checks++;
        if (evq.size() != 1) begin
            errors++; $display("FAIL t3_count got=%0d want=1", evq.size());
        end else begin
            checks++;
            if (evq[0] !== {2'b01, 4'd7, 8'h3D}) begin
                errors++; $display("FAIL t3_event got=%h want=173D", evq[0]);
            end
        end
    endtask

    task automatic test_overflow;
        evq.delete();
        evt_ready = 1'b0;
        for (int d = 0; d < 5; d++) press(12'h800 >> d, 8'h00);
        checks++;
        if (evt_valid !== 1'b1 || evt_ascii !== 8'h30) begin
            errors++;
            $display("FAIL t4_head got=%b/%h want=1/30", evt_valid, evt_ascii);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL t4_overflow got=%b want=1", overflow);
        end
        evt_ready = 1'b1;
        wait_clk(10);
        checks++;
        if (evq.size() != 4) begin
            errors++; $display("FAIL t4_count got=%0d want=4", evq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (evq[k] !== {2'b00, 4'(k), 8'(48 + k)}) begin
                    errors++;
                    $display("FAIL t4_order[%0d] got=%h want=%h", k, evq[k],
                             {2'b00, 4'(k), 8'(48 + k)});
                end
            end
        end
        checks++;
        if (evt_valid !== 1'b0 || evt_ascii !== 8'h33) begin
            errors++;
            $display("FAIL t4_drained got=%b/%h want=0/33", evt_valid, evt_ascii);
        end
    endtask

    task automatic test_reset_midstream;
        evt_ready = 1'b0;
        press(12'h800 >> 5, 8'h00);
        press(12'h800 >> 6, 8'h00);
        checks++;
        if (evt_valid !== 1'b1 || evt_ascii !== 8'h35) begin
            errors++;
            $display("FAIL t6_queued got=%b/%h want=1/35", evt_valid, evt_ascii);
        end
        sw = 12'h010;
        wait_clk(4);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL t6_mid_debounce got=%b want=0", key_held);
        end
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL t6_after_rst got=%b%b%b want=000",
                     evt_valid, overflow, key_held);
        end
        checks++;
        if (evt_ascii !== 8'h20) begin
            errors++; $display("FAIL t6_rst_ascii got=%h want=20", evt_ascii);
        end
        evq.delete();
        evt_ready = 1'b1;
        wait_clk(30);
        sw = '0;
        wait_clk(30);
        checks++;
        if (evq.size() != 1) begin
            errors++; $display("FAIL t6_count got=%0d want=1", evq.size());
        end else begin
            checks++;
            if (evq[0] !== {2'b00, 4'd7, 8'h37}) begin
                errors++; $display("FAIL t6_event got=%h want=0737", evq[0]);
            end
        end
    endtask

    task automatic test_full_push_pop;
        evq.delete();
        evt_ready = 1'b0;
        for (int d = 0; d < 4; d++) press(12'h800 >> d, 8'h00);
        sw = 12'h800 >> 4;
        for (int i = 0; i < 40 && !key_held; i++) @(negedge clk);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL t5_timeout got=%b want=1", key_held);
        end
        // stable rose at the last edge; the push lands two edges later
        wait_clk(1);
        evt_ready = 1'b1;
        wait_clk(1);
        evt_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL t5_overflow got=%b want=0", overflow);
        end
        sw = '0;
        wait_clk(20);
        evt_ready = 1'b1;
        wait_clk(10);
        checks++;
        if (evq.size() != 5) begin
            errors++; $display("FAIL t5_count got=%0d want=5", evq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (evq[k] !== {2'b00, 4'(k), 8'(48 + k)}) begin
                    errors++;
                    $display("FAIL t5_order[%0d] got=%h want=%h", k, evq[k],
                             {2'b00, 4'(k), 8'(48 + k)});
                end
            end
        end
        evq.delete();
        press(12'h001, 8'h00);
        checks++;
        if (evq.size() != 1) begin
            errors++; $display("FAIL t5_clear_count got=%0d want=1", evq.size());
        end else begin
            checks++;
            if (evq[0] !== {2'b10, 4'd0, 8'h20}) begin
                errors++; $display("FAIL t5_clear got=%h want=2020", evq[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_bounce();
        test_invalid_and_op();
        test_overflow();
        test_reset_midstream();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
